// File: rtl/bsg_test_addr_gen_pkg.sv
// Shared types and helpers for the bandwidth-test address generator.
package bsg_test_addr_gen_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    STRIDE = 2'd1,
    RAND   = 2'd2,
    FIXED  = 2'd3
  } addr_gen_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } addr_gen_state_e;

  // Fibonacci feedback taps (bit i set = tap i+1). The top bit is always a tap,
  // which keeps the register invertible so a nonzero seed never reaches zero.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_00B8;
      9:       taps = 64'h0000_0110;
      10:      taps = 64'h0000_0240;
      11:      taps = 64'h0000_0500;
      12:      taps = 64'h0000_0829;
      13:      taps = 64'h0000_100D;
      14:      taps = 64'h0000_2015;
      15:      taps = 64'h0000_6000;
      16:      taps = 64'h0000_D008;
      32:      taps = 64'h8020_0003;
      default: taps = (64'd1 << (width - 1)) | (64'd1 << (width - 2));
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/bsg_test_addr_gen_lfsr.sv
// Seedable Fibonacci LFSR used for the random address pattern.
module bsg_lfsr
  import bsg_test_addr_gen_pkg::*;
#(
  parameter int          width_p = 16,
  parameter int unsigned seed_p  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  output logic [width_p-1:0] next_value
);

  localparam logic [width_p-1:0] taps = width_p'(lfsr_taps(width_p));
  localparam logic [width_p-1:0] seed = width_p'(seed_p);

  logic [width_p-1:0] state;

  // The value the register will hold after one step; the parent uses it directly.
  always_comb begin
    next_value = {state[width_p-2:0], ^(state & taps)};
  end

  // Reload the seed on reset or run start, otherwise step only when enabled.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= seed;
    end else if (en) begin
      state <= next_value;
    end
  end

endmodule

// File: rtl/bsg_test_addr_gen.sv
// Request-stream generator: emits a bounded run of block-aligned channel
// addresses over valid/yumi, counts read responses, and times the run.
module bsg_test_addr_gen
  import bsg_test_addr_gen_pkg::*;
#(
  parameter int          channel_addr_width_p = 16,
  parameter int          num_request_p        = 4,
  parameter int          block_offset_p       = 6,
  parameter int unsigned lfsr_seed_p          = 1,
  parameter int          cycle_width_p        = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic [1:0]                      mode_i,
  input  logic [channel_addr_width_p-1:0] stride_i,
  input  logic [channel_addr_width_p-1:0] base_addr_i,
  output logic                            v_o,
  output logic [channel_addr_width_p-1:0] ch_addr_o,
  input  logic                            yumi_i,
  input  logic                            dram_data_v_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [cycle_width_p-1:0]        cycle_count_o
);

  localparam int aw    = channel_addr_width_p;
  localparam int cnt_w = $clog2(num_request_p + 1);

  localparam logic [cnt_w-1:0] num_req      = cnt_w'(num_request_p);
  localparam logic [cnt_w-1:0] num_req_m1   = cnt_w'(num_request_p - 1);
  localparam logic [aw-1:0]    block_inc    = aw'(1) << block_offset_p;
  localparam logic [aw-1:0]    addr_mask    = ~(block_inc - aw'(1));

  addr_gen_state_e    state, state_next;
  addr_gen_mode_e     mode_r;
  logic [aw-1:0]      stride_r;
  logic [aw-1:0]      addr_r;
  logic [aw-1:0]      addr_step;
  logic [aw-1:0]      lfsr_next;
  logic [cnt_w-1:0]   sent_r;
  logic [cnt_w-1:0]   recv_r;
  logic [cnt_w-1:0]   recv_next;
  logic [cycle_width_p-1:0] cycle_r;
  logic               start_run;
  logic               accept;
  logic               last_send;
  logic               running;

  assign running   = (state == SEND) || (state == DRAIN);
  assign start_run = start_i && ((state == IDLE) || (state == DONE));
  assign accept    = (state == SEND) && yumi_i;
  assign last_send = accept && (sent_r == num_req_m1);

  assign v_o           = (state == SEND);
  assign busy_o        = running;
  assign done_o        = (state == DONE);
  assign ch_addr_o     = addr_r;
  assign cycle_count_o = cycle_r;

  bsg_lfsr #(
    .width_p (aw),
    .seed_p  (lfsr_seed_p)
  ) lfsr (
    .clk        (clk_i),
    .reset      (reset_i),
    .load       (start_run),
    .en         (accept && (mode_r == RAND)),
    .next_value (lfsr_next)
  );

  // Saturating response count, including this cycle's response, so completion is seen without delay.
  always_comb begin
    recv_next = recv_r;
    if (running && dram_data_v_i && (recv_r != num_req)) begin
      recv_next = recv_r + cnt_w'(1);
    end
  end

  // Address that follows the current one when the downstream accepts it.
  always_comb begin
    addr_step = addr_r;
    case (mode_r)
      SEQ:     addr_step = addr_r + block_inc;
      STRIDE:  addr_step = (addr_r + stride_r) & addr_mask;
      RAND:    addr_step = lfsr_next & addr_mask;
      FIXED:   addr_step = addr_r;
      default: addr_step = addr_r;
    endcase
  end

  // Next-state decode; a final accept that coincides with the final response skips DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = SEND;
      DONE:    if (start_i) state_next = SEND;
      SEND:    if (last_send) state_next = (recv_next == num_req) ? DONE : DRAIN;
      DRAIN:   if (recv_next == num_req) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any run in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run configuration capture, address register and the three counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_r   <= SEQ;
      stride_r <= '0;
      addr_r   <= '0;
      sent_r   <= '0;
      recv_r   <= '0;
      cycle_r  <= '0;
    end else if (start_run) begin
      mode_r   <= addr_gen_mode_e'(mode_i);
      stride_r <= stride_i;
      addr_r   <= base_addr_i & addr_mask;
      sent_r   <= '0;
      recv_r   <= '0;
      cycle_r  <= '0;
    end else begin
      if (accept) begin
        sent_r <= sent_r + cnt_w'(1);
        addr_r <= addr_step;
      end
      recv_r <= recv_next;
      if (running && (cycle_r != '1)) begin
        cycle_r <= cycle_r + cycle_width_p'(1);
      end
    end
  end

endmodule
